ddr_burst_master: RTL and testbench
===================================

Name: ddr_burst_master

Overview:
- Initiator side of the DDR user-port protocol: wr_req/rd_req, cmd_addr, bst_len, data_in, avl_be, ddr_rdy, ddr_vld, data_out.
- Accepts one transfer descriptor at a time (direction, beat address, beat count) from a CNN-layer DMA client.
- Splits the transfer into DDR bursts that never cross a MAX_BST-aligned boundary.
- Streams write beats in from the client, and streams read beats back to the client.

Parameters:
- ADDR_W, 26, beat (512-bit word) address width.
- DATA_W, 512, beat data width.
- BE_W, 64, byte-enable width (DATA_W/8).
- BST_W, 7, bst_len width.
- MAX_BST, 64, maximum burst length; power of two, 1..2^(BST_W-1).
- LEN_W, 16, transfer length width in beats.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- xfer_vld  in  1  descriptor valid
- xfer_rdy  out  1  descriptor accepted when xfer_vld&&xfer_rdy
- xfer_wr  in  1  1=write, 0=read
- xfer_addr  in  ADDR_W  start beat address
- xfer_len  in  LEN_W  number of beats; 0 is legal
- xfer_done  out  1  one-cycle pulse at transfer completion
- wdat_vld  in  1  write beat valid
- wdat_rdy  out  1  write beat consumed
- wdat  in  DATA_W  write beat data
- wbe  in  BE_W  write byte enables
- rdat_vld  out  1  read beat valid; no backpressure
- rdat  out  DATA_W  read beat data
- rdat_last  out  1  final read beat of the transfer
- err_unexp_vld  out  1  sticky: ddr_vld seen outside RD_DAT
- wr_req  out  1  write request / write beat valid
- rd_req  out  1  read burst request
- cmd_addr  out  ADDR_W  burst start address
- bst_len  out  BST_W  burst length in beats
- data_in  out  DATA_W  write data to DDR
- avl_be  out  BE_W  byte enables to DDR
- ddr_rdy  in  1  DDR accepts command/beat
- ddr_vld  in  1  DDR read data valid
- data_out  in  DATA_W  DDR read data

Behaviour:
- Clocking and reset: one clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE; counters 0.
  - wr_req, rd_req, rdat_vld, rdat_last, xfer_done, err_unexp_vld = 0.
  - cmd_addr, bst_len, rdat = 0.
  - xfer_rdy = 0 while rst is high.
  - Reset mid-transfer abandons it with no completion pulse; the DDR side is reset by the same rst.
- FSM states: IDLE, WR_BST, RD_CMD, RD_DAT, DONE.
- IDLE:
  - xfer_rdy = 1.
  - On accept: latch addr and len.
  - len==0 goes to DONE.
  - Otherwise compute the first burst and go to WR_BST (xfer_wr=1) or RD_CMD.
- Burst sizing: blen = min(remaining, MAX_BST - (addr mod MAX_BST)).
  - The next burst address is addr+blen, modulo 2^ADDR_W (wraps silently).
  - cmd_addr and bst_len are registered and stay constant for the whole burst.
- WR_BST:
  - wr_req = wdat_vld.
  - data_in = wdat and avl_be = wbe (combinational pass-through).
  - wdat_rdy = ddr_rdy.
  - A beat transfers when wr_req&&ddr_rdy; wdat_vld gaps mid-burst are legal.
  - On the last beat of a burst: if remaining>0, load the next burst and stay in WR_BST, with no idle cycle needed; otherwise go to DONE.
- RD_CMD:
  - rd_req = 1 until ddr_rdy.
  - On the cycle rd_req&&ddr_rdy, go to RD_DAT.
  - Exactly one read burst is outstanding at a time.
- RD_DAT:
  - Each ddr_vld produces rdat_vld one cycle later, with rdat = registered data_out.
  - rdat_last is high only on the final beat of the whole transfer.
  - After bst_len beats: go to RD_CMD if remaining>0, else DONE.
- DONE: xfer_done = 1 for one cycle, then IDLE.
  - For reads, xfer_done coincides with the registered last rdat beat.
- Outside WR_BST: wdat_rdy = 0 and wr_req = 0.
- Outside RD_CMD: rd_req = 0.
- ddr_vld outside RD_DAT: the beat is dropped and err_unexp_vld is set; it is cleared only by rst.
- Simultaneous wr_req and rd_req never occur.

Decomposition:
- ddr_burst_pkg holds:
  - width localparams (ADDR_W, DATA_W, BE_W, BST_W, LEN_W defaults);
  - MAX_BST;
  - the state enum typedef;
  - the descriptor struct typedef {wr, addr, len}.
- Sub-module ddr_burst_split is combinational and computes blen and next_addr from addr and remaining.

Test Plan:
- Write, addr 0x10, len 8 -> one burst: cmd_addr 0x10, bst_len 8, 8 beats with wr_req; xfer_done 1 cycle after the 8th accepted beat.
- Write, addr 0x3C, len 10 -> bursts (0x3C,4) then (0x40,6); data order preserved; no beat crosses 0x40 in the first burst.
- Read, addr 0, len 130 -> rd_req bursts (0,64), (64,64), (128,2); 130 rdat_vld beats each 1 cycle after ddr_vld; rdat_last only on beat 130.
- Write len 20 with random ddr_rdy and wdat_vld gaps -> exactly 20 beats accepted, data and byte enables match input order, bst_len constant during each burst.
- len 0 (read or write) -> xfer_done the cycle after IDLE; no wr_req or rd_req ever asserted.
- rst asserted mid-RD_DAT -> next cycle all outputs 0 and xfer_rdy=1 after rst drops; ddr_vld in IDLE -> err_unexp_vld=1 and stays set.

Source files
------------

// File: rtl/ddr_burst_pkg.sv
// Shared widths, state encoding and descriptor type for the DDR burst master.
// Module-level parameters default to the values defined here.
package ddr_burst_pkg;

  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 512;
  localparam int BE_W    = 64;
  localparam int BST_W   = 7;
  localparam int LEN_W   = 16;
  localparam int MAX_BST = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_BST = 3'd1,
    ST_RD_CMD = 3'd2,
    ST_RD_DAT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } desc_t;

endpackage

// File: rtl/ddr_burst_split.sv
// Combinational burst sizer: the next burst is clipped so that it never
// crosses a MAX_BST-aligned boundary and never exceeds the remaining beats.
module ddr_burst_split #(
  parameter int ADDR_W  = ddr_burst_pkg::ADDR_W,
  parameter int BST_W   = ddr_burst_pkg::BST_W,
  parameter int LEN_W   = ddr_burst_pkg::LEN_W,
  parameter int MAX_BST = ddr_burst_pkg::MAX_BST
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  remaining,
  output logic [BST_W-1:0]  blen,
  output logic [ADDR_W-1:0] next_addr
);
  import ddr_burst_pkg::*;

  logic [BST_W-1:0] room;

  // MAX_BST is a power of two, so the offset inside the window is a mask.
  always_comb begin
    room = BST_W'(MAX_BST) - BST_W'(addr & ADDR_W'(MAX_BST - 1));
    if (32'(remaining) < 32'(room)) begin
      blen = BST_W'(remaining);
    end else begin
      blen = room;
    end
    next_addr = addr + ADDR_W'(blen);
  end

endmodule

// File: rtl/ddr_burst_master.sv
// Initiator for the DDR user port: accepts one transfer descriptor at a time,
// splits it into window-aligned bursts and streams write/read beats.
module ddr_burst_master #(
  parameter int ADDR_W  = ddr_burst_pkg::ADDR_W,
  parameter int DATA_W  = ddr_burst_pkg::DATA_W,
  parameter int BE_W    = ddr_burst_pkg::BE_W,
  parameter int BST_W   = ddr_burst_pkg::BST_W,
  parameter int MAX_BST = ddr_burst_pkg::MAX_BST,
  parameter int LEN_W   = ddr_burst_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xfer_vld,
  output logic              xfer_rdy,
  input  logic              xfer_wr,
  input  logic [ADDR_W-1:0] xfer_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  output logic              xfer_done,
  input  logic              wdat_vld,
  output logic              wdat_rdy,
  input  logic [DATA_W-1:0] wdat,
  input  logic [BE_W-1:0]   wbe,
  output logic              rdat_vld,
  output logic [DATA_W-1:0] rdat,
  output logic              rdat_last,
  output logic              err_unexp_vld,
  output logic              wr_req,
  output logic              rd_req,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [BST_W-1:0]  bst_len,
  output logic [DATA_W-1:0] data_in,
  output logic [BE_W-1:0]   avl_be,
  input  logic              ddr_rdy,
  input  logic              ddr_vld,
  input  logic [DATA_W-1:0] data_out
);
  import ddr_burst_pkg::*;

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] WR_BST = ST_WR_BST;
  localparam logic [2:0] RD_CMD = ST_RD_CMD;
  localparam logic [2:0] RD_DAT = ST_RD_DAT;
  localparam logic [2:0] DONE   = ST_DONE;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [BST_W-1:0]  bst_len_q, bst_len_d;
  logic [BST_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              rdat_vld_q, rdat_vld_d;
  logic              rdat_last_q, rdat_last_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] split_addr;
  logic [LEN_W-1:0]  split_rem;
  logic [BST_W-1:0]  split_blen;
  logic [ADDR_W-1:0] split_next;
  logic              load_burst;
  logic              last_beat;

  // addr_q/rem_q describe what is left after the burst currently on the port.
  assign split_addr = (state_q == IDLE) ? xfer_addr : addr_q;
  assign split_rem  = (state_q == IDLE) ? xfer_len  : rem_q;
  assign last_beat  = (beat_cnt_q == bst_len_q - BST_W'(1));

  ddr_burst_split #(
    .ADDR_W  (ADDR_W),
    .BST_W   (BST_W),
    .LEN_W   (LEN_W),
    .MAX_BST (MAX_BST)
  ) u_split (
    .addr      (split_addr),
    .remaining (split_rem),
    .blen      (split_blen),
    .next_addr (split_next)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cmd_addr_d  = cmd_addr_q;
    bst_len_d   = bst_len_q;
    beat_cnt_d  = beat_cnt_q;
    rdat_vld_d  = 1'b0;
    rdat_last_d = 1'b0;
    rdat_d      = rdat_q;
    err_d       = err_q | (ddr_vld && (state_q != RD_DAT));
    load_burst  = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer_vld) begin
          if (xfer_len == '0) begin
            state_d = DONE;
          end else begin
            load_burst = 1'b1;
            state_d    = xfer_wr ? WR_BST : RD_CMD;
          end
        end
      end
      WR_BST: begin
        if (wdat_vld && ddr_rdy) begin
          if (last_beat) begin
            if (rem_q != '0) begin
              load_burst = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BST_W'(1);
          end
        end
      end
      RD_CMD: begin
        if (ddr_rdy) begin
          state_d    = RD_DAT;
          beat_cnt_d = '0;
        end
      end
      RD_DAT: begin
        if (ddr_vld) begin
          rdat_vld_d = 1'b1;
          rdat_d     = data_out;
          if (last_beat) begin
            rdat_last_d = (rem_q == '0);
            if (rem_q != '0) begin
              load_burst = 1'b1;
              state_d    = RD_CMD;
            end else begin
              state_d = DONE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BST_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Back-to-back bursts reload here so writes need no idle cycle between them.
    if (load_burst) begin
      cmd_addr_d = split_addr;
      bst_len_d  = split_blen;
      addr_d     = split_next;
      rem_d      = split_rem - LEN_W'(split_blen);
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cmd_addr_q  <= '0;
      bst_len_q   <= '0;
      beat_cnt_q  <= '0;
      rdat_vld_q  <= 1'b0;
      rdat_last_q <= 1'b0;
      rdat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cmd_addr_q  <= cmd_addr_d;
      bst_len_q   <= bst_len_d;
      beat_cnt_q  <= beat_cnt_d;
      rdat_vld_q  <= rdat_vld_d;
      rdat_last_q <= rdat_last_d;
      rdat_q      <= rdat_d;
      err_q       <= err_d;
    end
  end

  assign xfer_rdy      = (state_q == IDLE) && !rst;
  assign xfer_done     = (state_q == DONE);
  assign wr_req        = (state_q == WR_BST) && wdat_vld;
  assign wdat_rdy      = (state_q == WR_BST) && ddr_rdy;
  assign rd_req        = (state_q == RD_CMD);
  assign data_in       = wdat;
  assign avl_be        = wbe;
  assign cmd_addr      = cmd_addr_q;
  assign bst_len       = bst_len_q;
  assign rdat_vld      = rdat_vld_q;
  assign rdat_last     = rdat_last_q;
  assign rdat          = rdat_q;
  assign err_unexp_vld = err_q;

endmodule

// File: tb/tb_ddr_burst_master.sv
// Directed testbench for ddr_burst_master: the bench plays both the DMA client
// and the DDR controller and checks every beat against hand-derived values.
module tb_ddr_burst_master;

  logic          clk;
  logic          rst;
  logic          xfer_vld;
  logic          xfer_rdy;
  logic          xfer_wr;
  logic [25:0]   xfer_addr;
  logic [15:0]   xfer_len;
  logic          xfer_done;
  logic          wdat_vld;
  logic          wdat_rdy;
  logic [511:0]  wdat;
  logic [63:0]   wbe;
  logic          rdat_vld;
  logic [511:0]  rdat;
  logic          rdat_last;
  logic          err_unexp_vld;
  logic          wr_req;
  logic          rd_req;
  logic [25:0]   cmd_addr;
  logic [6:0]    bst_len;
  logic [511:0]  data_in;
  logic [63:0]   avl_be;
  logic          ddr_rdy;
  logic          ddr_vld;
  logic [511:0]  data_out;

  int n_cmp;
  int n_err;

  ddr_burst_master dut (
    .clk           (clk),
    .rst           (rst),
    .xfer_vld      (xfer_vld),
    .xfer_rdy      (xfer_rdy),
    .xfer_wr       (xfer_wr),
    .xfer_addr     (xfer_addr),
    .xfer_len      (xfer_len),
    .xfer_done     (xfer_done),
    .wdat_vld      (wdat_vld),
    .wdat_rdy      (wdat_rdy),
    .wdat          (wdat),
    .wbe           (wbe),
    .rdat_vld      (rdat_vld),
    .rdat          (rdat),
    .rdat_last     (rdat_last),
    .err_unexp_vld (err_unexp_vld),
    .wr_req        (wr_req),
    .rd_req        (rd_req),
    .cmd_addr      (cmd_addr),
    .bst_len       (bst_len),
    .data_in       (data_in),
    .avl_be        (avl_be),
    .ddr_rdy       (ddr_rdy),
    .ddr_vld       (ddr_vld),
    .data_out      (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input int k);
    pat = {16{32'hC0DE_0000 + 32'(k)}};
  endfunction

  function automatic logic [63:0] bpat(input int k);
    bpat = {2{32'hBE00_0000 ^ 32'(k * 7)}};
  endfunction

  // Reset values must hold while rst is high; xfer_rdy rises once it drops.
  task test_reset;
    rst = 1'b1; xfer_vld = 1'b0; xfer_wr = 1'b0; xfer_addr = '0; xfer_len = '0;
    wdat_vld = 1'b0; wdat = '0; wbe = '0; ddr_rdy = 1'b0; ddr_vld = 1'b0; data_out = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({xfer_rdy, wr_req, rd_req, rdat_vld, rdat_last, xfer_done, err_unexp_vld} !== 7'b0) begin n_err++; $display("[TB] FAIL reset_flags: got %b want 0000000", {xfer_rdy, wr_req, rd_req, rdat_vld, rdat_last, xfer_done, err_unexp_vld}); end
    n_cmp++; if ({cmd_addr, bst_len} !== 33'h0) begin n_err++; $display("[TB] FAIL reset_cmd: got %h want 0", {cmd_addr, bst_len}); end
    n_cmp++; if (rdat !== 512'h0) begin n_err++; $display("[TB] FAIL reset_rdat: got %h want 0", rdat); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (xfer_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL reset_rdy: got %b want 1", xfer_rdy); end
  endtask

  // Write 0x10 len 8: one burst, xfer_done one cycle after the 8th beat.
  task test_write_single;
    @(negedge clk);
    xfer_vld = 1'b1; xfer_wr = 1'b1; xfer_addr = 26'h10; xfer_len = 16'd8;
    #1;
    n_cmp++; if (xfer_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL ws_accept: got %b want 1", xfer_rdy); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      xfer_vld = 1'b0; wdat_vld = 1'b1; ddr_rdy = 1'b1; wdat = pat(k); wbe = bpat(k);
      #1;
      n_cmp++; if ({wr_req, wdat_rdy, xfer_done} !== 3'b110) begin n_err++; $display("[TB] FAIL ws_hs beat %0d: got %b want 110", k, {wr_req, wdat_rdy, xfer_done}); end
      n_cmp++; if ({cmd_addr, bst_len} !== {26'h10, 7'd8}) begin n_err++; $display("[TB] FAIL ws_cmd beat %0d: got %h/%0d want 10/8", k, cmd_addr, bst_len); end
      n_cmp++; if ({data_in, avl_be} !== {pat(k), bpat(k)}) begin n_err++; $display("[TB] FAIL ws_data beat %0d: got %h want %h", k, avl_be, bpat(k)); end
    end
    @(negedge clk);
    wdat_vld = 1'b0;
    #1;
    n_cmp++; if ({xfer_done, wr_req} !== 2'b10) begin n_err++; $display("[TB] FAIL ws_done: got %b want 10", {xfer_done, wr_req}); end
    @(negedge clk);
    #1;
    n_cmp++; if ({xfer_done, xfer_rdy} !== 2'b01) begin n_err++; $display("[TB] FAIL ws_idle: got %b want 01", {xfer_done, xfer_rdy}); end
  endtask

  // Write 0x3C len 10: split at the 0x40 boundary into (0x3C,4) then (0x40,6).
  task test_write_cross;
    logic [25:0] ea;
    logic [6:0]  el;
    @(negedge clk);
    xfer_vld = 1'b1; xfer_wr = 1'b1; xfer_addr = 26'h3C; xfer_len = 16'd10;
    #1;
    n_cmp++; if (xfer_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL wc_accept: got %b want 1", xfer_rdy); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      xfer_vld = 1'b0; wdat_vld = 1'b1; ddr_rdy = 1'b1; wdat = pat(50 + k); wbe = bpat(50 + k);
      ea = (k < 4) ? 26'h3C : 26'h40;
      el = (k < 4) ? 7'd4 : 7'd6;
      #1;
      n_cmp++; if ({cmd_addr, bst_len} !== {ea, el}) begin n_err++; $display("[TB] FAIL wc_cmd beat %0d: got %h/%0d want %h/%0d", k, cmd_addr, bst_len, ea, el); end
      n_cmp++; if ({wr_req, xfer_done} !== 2'b10) begin n_err++; $display("[TB] FAIL wc_hs beat %0d: got %b want 10", k, {wr_req, xfer_done}); end
      n_cmp++; if (data_in !== pat(50 + k)) begin n_err++; $display("[TB] FAIL wc_data beat %0d: got %h", k, data_in[31:0]); end
    end
    @(negedge clk);
    wdat_vld = 1'b0;
    #1;
    n_cmp++; if ({xfer_done, wr_req} !== 2'b10) begin n_err++; $display("[TB] FAIL wc_done: got %b want 10", {xfer_done, wr_req}); end
    @(negedge clk);
  endtask

  // Write 0x3A len 20 with random gaps on both sides: bursts (0x3A,6), (0x40,14).
  task test_write_random;
    int sent;
    int cyc;
    logic [25:0] ea;
    logic [6:0]  el;
    @(negedge clk);
    xfer_vld = 1'b1; xfer_wr = 1'b1; xfer_addr = 26'h3A; xfer_len = 16'd20;
    #1;
    n_cmp++; if (xfer_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL wr_accept: got %b want 1", xfer_rdy); end
    sent = 0;
    cyc  = 0;
    while (sent < 20 && cyc < 400) begin
      @(negedge clk);
      xfer_vld = 1'b0;
      wdat_vld = ($urandom_range(0, 3) != 0);
      ddr_rdy  = ($urandom_range(0, 2) != 0);
      wdat = pat(100 + sent); wbe = bpat(100 + sent);
      ea = (sent < 6) ? 26'h3A : 26'h40;
      el = (sent < 6) ? 7'd6 : 7'd14;
      #1;
      n_cmp++; if ({wr_req, wdat_rdy, xfer_done} !== {wdat_vld, ddr_rdy, 1'b0}) begin n_err++; $display("[TB] FAIL wr_hs cyc %0d: got %b want %b", cyc, {wr_req, wdat_rdy, xfer_done}, {wdat_vld, ddr_rdy, 1'b0}); end
      n_cmp++; if ({cmd_addr, bst_len} !== {ea, el}) begin n_err++; $display("[TB] FAIL wr_cmd beat %0d: got %h/%0d want %h/%0d", sent, cmd_addr, bst_len, ea, el); end
      if (wr_req && ddr_rdy) begin
        n_cmp++; if ({data_in, avl_be} !== {pat(100 + sent), bpat(100 + sent)}) begin n_err++; $display("[TB] FAIL wr_data beat %0d: got %h want %h", sent, avl_be, bpat(100 + sent)); end
        sent++;
      end
      cyc++;
    end
    n_cmp++; if (sent !== 20) begin n_err++; $display("[TB] FAIL wr_count: got %0d want 20", sent); end
    @(negedge clk);
    wdat_vld = 1'b1; ddr_rdy = 1'b1;
    #1;
    n_cmp++; if ({xfer_done, wr_req} !== 2'b10) begin n_err++; $display("[TB] FAIL wr_done: got %b want 10", {xfer_done, wr_req}); end
    @(negedge clk);
    wdat_vld = 1'b0; ddr_rdy = 1'b0;
    #1;
    n_cmp++; if (xfer_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL wr_idle: got %b want 1", xfer_rdy); end
  endtask

  // Read 0 len 130: bursts (0,64), (64,64), (128,2); rdat one cycle after ddr_vld.
  task test_read_long;
    int ea[3];
    int el[3];
    int bi, pending, idx, prev_idx, got, cyc;
    logic prev_vld;
    ea = '{0, 64, 128};
    el = '{64, 64, 2};
    bi = 0; pending = 0; idx = 0; prev_idx = 0; got = 0; cyc = 0; prev_vld = 1'b0;
    @(negedge clk);
    xfer_vld = 1'b1; xfer_wr = 1'b0; xfer_addr = 26'h0; xfer_len = 16'd130;
    #1;
    n_cmp++; if (xfer_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL rl_accept: got %b want 1", xfer_rdy); end
    while (idx < 130 && cyc < 2000) begin
      @(negedge clk);
      xfer_vld = 1'b0;
      ddr_rdy  = ((cyc % 3) != 1);
      ddr_vld  = (pending > 0) && ((cyc % 5) != 3);
      data_out = pat(200 + idx);
      #1;
      n_cmp++; if ({rdat_vld, xfer_done, wr_req} !== {prev_vld, 2'b00}) begin n_err++; $display("[TB] FAIL rl_vld cyc %0d: got %b want %b00", cyc, {rdat_vld, xfer_done, wr_req}, prev_vld); end
      if (rdat_vld) begin
        got++;
        n_cmp++; if ({rdat, rdat_last} !== {pat(200 + prev_idx), 1'b0}) begin n_err++; $display("[TB] FAIL rl_data beat %0d: got %h last %b", prev_idx, rdat[31:0], rdat_last); end
      end
      if (rd_req && ddr_rdy) begin
        if (bi < 3) begin
          n_cmp++; if ({cmd_addr, bst_len} !== {26'(ea[bi]), 7'(el[bi])}) begin n_err++; $display("[TB] FAIL rl_cmd burst %0d: got %h/%0d want %h/%0d", bi, cmd_addr, bst_len, ea[bi], el[bi]); end
          pending = el[bi];
        end else begin
          n_cmp++; n_err++; $display("[TB] FAIL rl_extra_burst: got burst %0d want at most 3", bi);
        end
        bi++;
      end
      prev_vld = ddr_vld;
      prev_idx = idx;
      if (ddr_vld) begin
        pending--;
        idx++;
      end
      cyc++;
    end
    @(negedge clk);
    ddr_vld = 1'b0;
    #1;
    if (rdat_vld) got++;
    n_cmp++; if ({rdat_vld, rdat_last, xfer_done} !== 3'b111) begin n_err++; $display("[TB] FAIL rl_last: got %b want 111", {rdat_vld, rdat_last, xfer_done}); end
    n_cmp++; if (rdat !== pat(329)) begin n_err++; $display("[TB] FAIL rl_last_data: got %h want %h", rdat[31:0], 32'hC0DE_0149); end
    n_cmp++; if ({got, bi} !== {32'd130, 32'd3}) begin n_err++; $display("[TB] FAIL rl_counts: got %0d beats %0d bursts want 130/3", got, bi); end
    @(negedge clk);
    #1;
    n_cmp++; if ({rdat_vld, rdat_last, xfer_rdy, err_unexp_vld} !== 4'b0010) begin n_err++; $display("[TB] FAIL rl_idle: got %b want 0010", {rdat_vld, rdat_last, xfer_rdy, err_unexp_vld}); end
  endtask

  // Zero-length transfers finish immediately without touching the DDR port.
  task test_len_zero;
    for (int w = 1; w >= 0; w--) begin
      @(negedge clk);
      xfer_vld = 1'b1; xfer_wr = w[0]; xfer_addr = 26'h123; xfer_len = 16'd0;
      wdat_vld = 1'b1; ddr_rdy = 1'b1;
      #1;
      n_cmp++; if ({xfer_rdy, wr_req, rd_req} !== 3'b100) begin n_err++; $display("[TB] FAIL lz_accept wr=%0d: got %b want 100", w, {xfer_rdy, wr_req, rd_req}); end
      @(negedge clk);
      xfer_vld = 1'b0;
      #1;
      n_cmp++; if ({xfer_done, wr_req, rd_req} !== 3'b100) begin n_err++; $display("[TB] FAIL lz_done wr=%0d: got %b want 100", w, {xfer_done, wr_req, rd_req}); end
      @(negedge clk);
      #1;
      n_cmp++; if ({xfer_done, xfer_rdy, wr_req, rd_req} !== 4'b0100) begin n_err++; $display("[TB] FAIL lz_idle wr=%0d: got %b want 0100", w, {xfer_done, xfer_rdy, wr_req, rd_req}); end
    end
    wdat_vld = 1'b0; ddr_rdy = 1'b0;
  endtask

  // Reset in the middle of a read burst, then a stray ddr_vld while idle.
  task test_reset_mid;
    @(negedge clk);
    xfer_vld = 1'b1; xfer_wr = 1'b0; xfer_addr = 26'h5; xfer_len = 16'd4;
    #1;
    n_cmp++; if (xfer_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL rm_accept: got %b want 1", xfer_rdy); end
    @(negedge clk);
    xfer_vld = 1'b0; ddr_rdy = 1'b1;
    #1;
    n_cmp++; if ({rd_req, cmd_addr, bst_len} !== {1'b1, 26'h5, 7'd4}) begin n_err++; $display("[TB] FAIL rm_cmd: got %b/%h/%0d want 1/5/4", rd_req, cmd_addr, bst_len); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ddr_rdy = 1'b0; ddr_vld = 1'b1; data_out = pat(400 + k);
    end
    #1;
    n_cmp++; if ({rdat_vld, rdat_last, rdat} !== {2'b10, pat(400)}) begin n_err++; $display("[TB] FAIL rm_beat0: got %b%b %h", rdat_vld, rdat_last, rdat[31:0]); end
    @(negedge clk);
    ddr_vld = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if ({xfer_rdy, wr_req, rd_req, rdat_vld, rdat_last, xfer_done, err_unexp_vld} !== 7'b0) begin n_err++; $display("[TB] FAIL rm_rst_flags: got %b want 0000000", {xfer_rdy, wr_req, rd_req, rdat_vld, rdat_last, xfer_done, err_unexp_vld}); end
    n_cmp++; if ({cmd_addr, bst_len, rdat} !== 545'h0) begin n_err++; $display("[TB] FAIL rm_rst_regs: got %h/%0d want 0/0", cmd_addr, bst_len); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if ({xfer_rdy, xfer_done, rdat_vld} !== 3'b100) begin n_err++; $display("[TB] FAIL rm_after: got %b want 100", {xfer_rdy, xfer_done, rdat_vld}); end
    ddr_vld = 1'b1; data_out = pat(999);
    @(negedge clk);
    ddr_vld = 1'b0;
    #1;
    n_cmp++; if ({err_unexp_vld, rdat_vld} !== 2'b10) begin n_err++; $display("[TB] FAIL rm_err_set: got %b want 10", {err_unexp_vld, rdat_vld}); end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (err_unexp_vld !== 1'b1) begin n_err++; $display("[TB] FAIL rm_err_sticky: got %b want 1", err_unexp_vld); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (err_unexp_vld !== 1'b0) begin n_err++; $display("[TB] FAIL rm_err_clear: got %b want 0", err_unexp_vld); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_single();
    test_write_cross();
    test_write_random();
    test_read_long();
    test_len_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
